// File: rtl/i2c_slave.sv
// i2c_slave: byte-oriented I2C target with a fixed 7-bit address.
//
// SCL/SDA are oversampled on clk. START/STOP are detected, the address byte is decoded,
// received write bytes are presented on rx_data/rx_valid, and on a read the byte on
// data_out is shifted out MSB first. SDA is open-drain (sda_out: 0 = pull low,
// 1 = release). SCL is never driven, so there is no clock stretching.
//
// Optional build macro:
//   I2C_SLAVE_GENCALL_EN - also ACK the general-call write address (byte 8'h00). Received
//                          bytes then appear on rx_data. General call with R/W=1 is NACKed.
//
// Ports:
//   clk                 system clock, at least 8x the SCL frequency
//   rst_n               asynchronous active-low reset
//   repeated_start_cond 1 = honour a repeated START mid-transfer, 0 = abort to idle
//   data_out[7:0]       byte to transmit on a read, sampled at the preceding ACK
//   scl_in, sda_in      pad inputs
//   sda_out             open-drain SDA control
//   rx_data[7:0]        last byte received in a write
//   rx_valid            one-clk pulse when rx_data updates
//   rw_read             R/W bit of the current transaction (1 = read)
//   busy                high from an addressed START until STOP or abort
module i2c_slave #(
  parameter logic [6:0]  SLAVE_ADDR  = 7'h2A,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       repeated_start_cond,
  input  logic [7:0] data_out,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_out,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rw_read,
  output logic       busy
);

  typedef enum logic [2:0] {
    StIdle, StAddr, StAddrAck, StRx, StRxAck, StTx, StTxAck
  } state_e;

  // Synchronizers plus one delay flop for edge detection; all reset to the idle bus level.
  logic [SYNC_STAGES-1:0] scl_sync_q, sda_sync_q;
  logic                   scl_dly_q, sda_dly_q;
  logic                   scl_s, sda_s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_dly_q  <= 1'b1;
      sda_dly_q  <= 1'b1;
    end else begin
      scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl_in};
      sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_in};
      scl_dly_q  <= scl_s;
      sda_dly_q  <= sda_s;
    end
  end

  assign scl_s = scl_sync_q[SYNC_STAGES-1];
  assign sda_s = sda_sync_q[SYNC_STAGES-1];

  logic scl_rise, scl_fall, start_det, stop_det;
  assign scl_rise  = scl_s & ~scl_dly_q;
  assign scl_fall  = ~scl_s & scl_dly_q;
  // SDA edges only count as bus conditions when SCL is high on both samples.
  assign start_det = scl_s & scl_dly_q & sda_dly_q & ~sda_s;
  assign stop_det  = scl_s & scl_dly_q & ~sda_dly_q & sda_s;

  state_e     state_q;
  logic [3:0] bit_cnt_q;
  logic [7:0] shift_q;
  logic       phase_q;     // ACK states: 0 = waiting for the fall that opens the ACK bit
  logic       sda_q;
  logic [7:0] rx_data_q;
  logic       rx_valid_q;
  logic       rw_q;
  logic       busy_q;

  logic [7:0] rx_byte;
  logic       addr_hit;
  assign rx_byte = {shift_q[6:0], sda_s};

`ifdef I2C_SLAVE_GENCALL_EN
  assign addr_hit = (rx_byte[7:1] == SLAVE_ADDR) || (rx_byte == 8'h00);
`else
  assign addr_hit = (rx_byte[7:1] == SLAVE_ADDR);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      bit_cnt_q  <= 4'd0;
      shift_q    <= 8'h00;
      phase_q    <= 1'b0;
      sda_q      <= 1'b1;
      rx_data_q  <= 8'h00;
      rx_valid_q <= 1'b0;
      rw_q       <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      rx_valid_q <= 1'b0;
      if (stop_det) begin
        state_q   <= StIdle;
        sda_q     <= 1'b1;
        busy_q    <= 1'b0;
        bit_cnt_q <= 4'd0;
        phase_q   <= 1'b0;
      end else if (start_det) begin
        sda_q     <= 1'b1;
        bit_cnt_q <= 4'd0;
        phase_q   <= 1'b0;
        if (state_q == StIdle || repeated_start_cond) begin
          state_q <= StAddr;
        end else begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
      end else begin
        unique case (state_q)
          StIdle: ;
          StAddr: begin
            if (scl_rise) begin
              shift_q   <= rx_byte;
              bit_cnt_q <= bit_cnt_q + 4'd1;
              if (bit_cnt_q == 4'd7) begin
                if (addr_hit) begin
                  state_q <= StAddrAck;
                  rw_q    <= rx_byte[0];
                  busy_q  <= 1'b1;
                  phase_q <= 1'b0;
                end else begin
                  // Not ours: stay released until the next START.
                  state_q <= StIdle;
                  busy_q  <= 1'b0;
                end
              end
            end
          end
          StAddrAck: begin
            if (scl_fall) begin
              if (!phase_q) begin
                sda_q   <= 1'b0;
                phase_q <= 1'b1;
                if (rw_q) shift_q <= data_out;
              end else begin
                phase_q   <= 1'b0;
                bit_cnt_q <= 4'd0;
                if (rw_q) begin
                  state_q <= StTx;
                  sda_q   <= shift_q[7];
                end else begin
                  state_q <= StRx;
                  sda_q   <= 1'b1;
                end
              end
            end
          end
          StRx: begin
            if (scl_rise) begin
              shift_q   <= rx_byte;
              bit_cnt_q <= bit_cnt_q + 4'd1;
              if (bit_cnt_q == 4'd7) begin
                rx_data_q  <= rx_byte;
                rx_valid_q <= 1'b1;
                state_q    <= StRxAck;
                phase_q    <= 1'b0;
              end
            end
          end
          StRxAck: begin
            if (scl_fall) begin
              if (!phase_q) begin
                sda_q   <= 1'b0;
                phase_q <= 1'b1;
              end else begin
                sda_q     <= 1'b1;
                phase_q   <= 1'b0;
                bit_cnt_q <= 4'd0;
                state_q   <= StRx;
              end
            end
          end
          StTx: begin
            if (scl_rise) begin
              bit_cnt_q <= bit_cnt_q + 4'd1;
            end else if (scl_fall) begin
              if (bit_cnt_q == 4'd8) begin
                sda_q   <= 1'b1;
                phase_q <= 1'b0;
                state_q <= StTxAck;
              end else begin
                shift_q <= {shift_q[6:0], 1'b0};
                sda_q   <= shift_q[6];
              end
            end
          end
          StTxAck: begin
            if (scl_rise && !phase_q) begin
              if (!sda_s) begin
                shift_q <= data_out;
                phase_q <= 1'b1;
              end else begin
                // Host NACK: release and wait; busy is only cleared by STOP.
                state_q <= StIdle;
                sda_q   <= 1'b1;
              end
            end else if (scl_fall && phase_q) begin
              state_q   <= StTx;
              sda_q     <= shift_q[7];
              bit_cnt_q <= 4'd0;
              phase_q   <= 1'b0;
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  assign sda_out  = sda_q;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign rw_read  = rw_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_i2c_slave.sv
// Testbench for i2c_slave: a bus-level host model drives SCL/SDA, a transaction-level
// reference decides what the target must put on SDA in every bit slot, and one compare
// process checks sda_out/busy/rx_valid against it each clock.
module tb_i2c_slave;

  localparam int Q = 6;  // clk cycles per quarter SCL period

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       repeated_start_cond = 1'b0;
  logic [7:0] data_out = 8'h00;
  logic       scl_h = 1'b1;
  logic       sda_h = 1'b1;
  logic       sda_bus;
  logic       sda_out;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rw_read;
  logic       busy;

  assign sda_bus = sda_h & sda_out;

  i2c_slave dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .repeated_start_cond (repeated_start_cond),
    .data_out            (data_out),
    .scl_in              (scl_h),
    .sda_in              (sda_bus),
    .sda_out             (sda_out),
    .rx_data             (rx_data),
    .rx_valid            (rx_valid),
    .rw_read             (rw_read),
    .busy                (busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int n_rxv    = 0;

  // Reference state
  logic       exp_sda  = 1'b1;
  logic       exp_busy = 1'b0;
  logic       chk_sda  = 1'b0;
  logic       chk_busy = 1'b0;
  logic [7:0] exp_rx[$];
  bit         m_busy = 1'b0;
  bit         m_idle = 1'b1;

  // Captures for literal checks
  logic       last_sda;
  logic       cap_ack;
  logic       cap_dack;
  logic [7:0] cap_byte;

  function automatic bit addr_ok(input logic [7:0] ab);
`ifdef I2C_SLAVE_GENCALL_EN
    return (ab[7:1] == 7'h2A) || (ab == 8'h00);
`else
    return (ab[7:1] == 7'h2A);
`endif
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_sda) begin
      n_checks++;
      if (sda_out !== exp_sda) begin
        n_fail++;
        $display("FAIL sda_out: got %0b, expected %0b (t=%0t)", sda_out, exp_sda, $time);
      end
    end
    if (chk_busy) begin
      n_checks++;
      if (busy !== exp_busy) begin
        n_fail++;
        $display("FAIL busy: got %0b, expected %0b (t=%0t)", busy, exp_busy, $time);
      end
    end
    if (rx_valid === 1'b1) begin
      n_rxv++;
      n_checks++;
      if (exp_rx.size() == 0) begin
        n_fail++;
        $display("FAIL rx_valid: got unexpected pulse, expected none (t=%0t)", $time);
      end else begin
        logic [7:0] e;
        e = exp_rx.pop_front();
        if (rx_data !== e) begin
          n_fail++;
          $display("FAIL rx_data: got %0h, expected %0h (t=%0t)", rx_data, e, $time);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One SCL bit: host drives b, the target must show exp_s on sda_out while SCL is high.
  task automatic send_bit(input logic b, input logic exp_s, input logic cb);
    sda_h = b;
    tick(Q);
    scl_h    = 1'b1;
    exp_sda  = exp_s;
    exp_busy = m_busy;
    tick(1);
    chk_sda  = 1'b1;
    chk_busy = cb;
    tick(Q - 1);
    last_sda = sda_out;
    tick(Q - 2);
    chk_sda  = 1'b0;
    chk_busy = 1'b0;
    tick(1);
    scl_h = 1'b0;
    tick(Q);
  endtask

  task automatic do_start();
    sda_h = 1'b0;
    tick(2 * Q);
    scl_h = 1'b0;
    tick(Q);
  endtask

  task automatic do_sr(output bit listen);
    listen = m_idle || repeated_start_cond;
    if (!m_idle && !repeated_start_cond) begin
      m_busy = 1'b0;
      m_idle = 1'b1;
    end
    sda_h = 1'b1;
    tick(Q);
    scl_h = 1'b1;
    tick(Q);
    sda_h = 1'b0;
    tick(Q);
    scl_h = 1'b0;
    tick(Q);
  endtask

  task automatic do_stop();
    sda_h = 1'b0;
    tick(Q);
    scl_h = 1'b1;
    tick(Q);
    sda_h = 1'b1;
    tick(2 * Q);
    m_busy = 1'b0;
    m_idle = 1'b1;
    check("busy_after_stop", busy, 0);
    check("sda_after_stop", sda_out, 1);
    check("rx_pending", exp_rx.size(), 0);
  endtask

  // Address byte ab, then nbytes data bytes; reads end with a host NACK.
  task automatic xfer(input logic [7:0] ab, input int nbytes, input bit listen,
                      input logic [7:0] first);
    bit         acked;
    logic [7:0] cur;
    logic [7:0] nxt;
    cur = first;
    if (ab[0]) data_out = cur;
    for (int i = 7; i >= 0; i--) send_bit(ab[i], 1'b1, i != 0);
    acked = listen && addr_ok(ab);
    if (listen) begin
      m_busy = acked;
      m_idle = !acked;
    end
    send_bit(1'b1, !acked, 1'b1);
    cap_ack = last_sda;
    if (acked) check("rw_read", rw_read, ab[0]);
    for (int k = 0; k < nbytes; k++) begin
      if (acked && ab[0]) begin
        for (int i = 7; i >= 0; i--) begin
          send_bit(1'b1, cur[i], 1'b1);
          if (k == 0) cap_byte[i] = last_sda;
          if (i == 7) begin
            nxt = 8'($urandom);
            data_out = nxt;
          end
        end
        send_bit((k == nbytes - 1), 1'b1, 1'b1);
        if (k == nbytes - 1) m_idle = 1'b1;
        cur = nxt;
      end else begin
        if (k > 0) cur = 8'($urandom);
        if (acked) exp_rx.push_back(cur);
        for (int i = 7; i >= 0; i--) send_bit(cur[i], 1'b1, 1'b1);
        send_bit(1'b1, !acked, 1'b1);
      end
      cap_dack = last_sda;
    end
  endtask

  initial begin
    bit listen;
    int snap;

    tick(4);
    check("rst_sda_out", sda_out, 1);
    check("rst_rx_data", rx_data, 0);
    check("rst_rx_valid", rx_valid, 0);
    check("rst_rw_read", rw_read, 0);
    check("rst_busy", busy, 0);
    rst_n = 1'b1;
    tick(4);

    // Read from 0x2A, data 0x55, host NACK
    do_start();
    xfer(8'h55, 1, 1'b1, 8'h55);
    check("rd_addr_ack", cap_ack, 0);
    check("rd_byte", cap_byte, 8'h55);
    check("rd_rw", rw_read, 1);
    check("rd_busy_after_nack", busy, 1);
    do_stop();

    // Write 0xA3 to 0x2A
    snap = n_rxv;
    do_start();
    xfer(8'h54, 1, 1'b1, 8'hA3);
    check("wr_addr_ack", cap_ack, 0);
    check("wr_data_ack", cap_dack, 0);
    check("wr_rx_data", rx_data, 8'hA3);
    check("wr_rx_pulses", n_rxv - snap, 1);
    do_stop();

    // Wrong address 0x30
    snap = n_rxv;
    do_start();
    xfer(8'h60, 1, 1'b1, 8'h5C);
    check("wrong_addr_ack", cap_ack, 1);
    check("wrong_busy", busy, 0);
    check("wrong_rx_pulses", n_rxv - snap, 0);
    do_stop();

    // Repeated start honoured
    repeated_start_cond = 1'b1;
    do_start();
    xfer(8'h54, 1, 1'b1, 8'h11);
    do_sr(listen);
    xfer(8'h55, 1, listen, 8'hC3);
    check("sr1_ack", cap_ack, 0);
    check("sr1_rw", rw_read, 1);
    check("sr1_byte", cap_byte, 8'hC3);
    do_stop();

    // Repeated start aborts
    repeated_start_cond = 1'b0;
    do_start();
    xfer(8'h54, 1, 1'b1, 8'h11);
    do_sr(listen);
    xfer(8'h55, 1, listen, 8'h3C);
    check("sr0_ack", cap_ack, 1);
    check("sr0_busy", busy, 0);
    do_stop();

    // General call
    snap = n_rxv;
    do_start();
    xfer(8'h00, 1, 1'b1, 8'h7E);
`ifdef I2C_SLAVE_GENCALL_EN
    check("gc_ack", cap_ack, 0);
    check("gc_rx_data", rx_data, 8'h7E);
    check("gc_rx_pulses", n_rxv - snap, 1);
`else
    check("gc_ack", cap_ack, 1);
    check("gc_rx_pulses", n_rxv - snap, 0);
`endif
    do_stop();

    // Randomized transactions
    for (int t = 0; t < 20; t++) begin
      int         nseg;
      int         kind;
      logic [7:0] ab;
      do_start();
      listen = 1'b1;
      nseg = $urandom_range(1, 2);
      for (int s = 0; s < nseg; s++) begin
        kind = $urandom_range(0, 4);
        case (kind)
          0: ab = 8'h54;
          1: ab = 8'h55;
          2: begin
            ab = 8'($urandom);
            if (ab[7:1] == 7'h2A || ab[7:1] == 7'h00) ab[7] = ~ab[7];
          end
          3: ab = 8'h00;
          default: ab = 8'h01;
        endcase
        xfer(ab, $urandom_range(1, 2), listen, 8'($urandom));
        if (s < nseg - 1) begin
          repeated_start_cond = 1'($urandom_range(0, 1));
          do_sr(listen);
        end
      end
      do_stop();
    end

    // Reset during the address ACK of a read must release SDA at once
    data_out = 8'h00;
    do_start();
    for (int i = 7; i >= 0; i--) send_bit(i == 0 ? 1'b1 : (8'h55 >> i) & 1'b1, 1'b1, 1'b0);
    sda_h = 1'b1;
    tick(Q);
    scl_h = 1'b1;
    tick(Q);
    check("pre_rst_ack_low", sda_out, 0);
    rst_n = 1'b0;
    #1;
    check("async_rst_sda", sda_out, 1);
    check("async_rst_busy", busy, 0);
    check("async_rst_rx_valid", rx_valid, 0);
    m_busy = 1'b0;
    m_idle = 1'b1;
    scl_h = 1'b0;
    tick(4);
    sda_h = 1'b0;
    rst_n = 1'b1;
    tick(Q);
    do_stop();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/i2c_slave.md
Name: i2c_slave

Overview:
- Byte-oriented I2C target with a fixed 7-bit address. Oversamples SCL/SDA on the system clock, detects START/STOP and decodes the address byte.
- On a read it shifts out a host-supplied byte. On a write it captures received bytes.
- Sits between the chip's I2C pads (open-drain, SDA only) and local register logic. Never drives SCL (no clock stretching).

Parameters:
- SLAVE_ADDR, 7'h2A, 7-bit address this target answers to.
- SYNC_STAGES, 2, synchronizer flops on scl_in/sda_in (min 2).

Ports:
- clk  input  1  system clock; must be at least 8x the SCL frequency.
- rst_n  input  1  asynchronous active-low reset.
- repeated_start_cond  input  1  1 = honour repeated START (Sr) mid-transfer; 0 = START inside a transfer aborts to IDLE.
- data_out  input  8  byte to transmit on read; sampled at the ACK of the address or previous byte.
- scl_in  input  1  SCL pad input.
- sda_in  input  1  SDA pad input.
- sda_out  output  1  SDA open-drain control: 0 = pull low, 1 = release.
- rx_data  output  8  last byte received in a write.
- rx_valid  output  1  one-clk pulse when rx_data updates.
- rw_read  output  1  R/W bit of the current transaction (1 = read).
- busy  output  1  high from an addressed START until STOP or abort.

Behaviour:
- Reset (async, rst_n=0): sda_out=1, rx_data=0, rx_valid=0, rw_read=0, busy=0, state=IDLE, bit counter=0. Synchronizer flops reset to 1.
- Edge detection: scl_in/sda_in pass through SYNC_STAGES flops, then one delay flop for edge detection. All decisions use the synchronized signals.
- Bus conditions:
  - START: SDA falls while SCL high.
  - STOP: SDA rises while SCL high.
  - Data bits are sampled on the SCL rising edge.
  - sda_out changes only on the clk after the SCL falling edge.
- States: IDLE, ADDR, ADDR_ACK, RX, RX_ACK, TX, TX_ACK.
- IDLE: START -> ADDR, bit counter=0.
- ADDR: shift 8 bits MSB first. After bit 8:
  - upper 7 bits == SLAVE_ADDR -> ADDR_ACK, rw_read=bit0, busy=1.
  - otherwise -> IDLE, sda_out stays 1 for the rest of the transaction.
- ADDR_ACK:
  - after SCL falls, drive sda_out=0 for one SCL period.
  - if rw_read, load shift register from data_out.
  - on the next SCL fall, go to TX (rw_read=1) or RX (rw_read=0).
  - when entering TX, sda_out=MSB immediately.
- RX: shift 8 bits. On the 8th rising edge, rx_data=byte and rx_valid pulses for 1 clk. Then RX_ACK drives 0 for one SCL period and returns to RX.
- TX:
  - present bits MSB first, each updated after an SCL fall.
  - after 8 bits, release SDA (sda_out=1) and go to TX_ACK.
- TX_ACK: sample the host's SDA on the SCL rise.
  - ACK (0): reload data_out and return to TX.
  - NACK (1): keep SDA released, go to IDLE, busy stays 1 until STOP.
- STOP in any state -> IDLE, sda_out=1, busy=0, counter cleared. STOP takes priority over any data edge in the same cycle.
- START while not IDLE:
  - repeated_start_cond=1 -> ADDR, counter=0, busy held.
  - repeated_start_cond=0 -> IDLE, busy=0, sda_out=1.
- A reset asserted mid-transfer releases SDA immediately (asynchronous).
- The target never drives SDA low while SCL is high, except ACK/data bits already set up before the SCL rise.

Optional Feature:
- I2C_SLAVE_GENCALL_EN defined: address byte 8'h00 (general call, write) is also ACKed, enters RX, and received bytes appear on rx_data/rx_valid. General call with R/W=1 is NACKed.
- Not defined: only SLAVE_ADDR is recognized, and 8'h00 is NACKed.

Test Plan:
- Reset: rst_n=0 mid-bit -> sda_out=1, busy=0, rx_valid=0 within 0 clk (async).
- Read from 0x2A: START, address byte 0x55, data_out=8'h55 -> ACK low in 9th SCL; next 8 SCL periods sda_out=0,1,0,1,0,1,0,1; host NACK -> SDA released; STOP -> busy=0.
- Write to 0x2A: address byte 0x54, then data 0xA3 -> two ACKs; rx_data=8'hA3 with one rx_valid pulse after the 8th data rise.
- Wrong address 0x30 (byte 0x60) -> sda_out stays 1 through the whole transaction, no rx_valid, busy=0.
- Repeated start: write 0x54, byte 0x11, then Sr plus 0x55 with repeated_start_cond=1 -> ACK and switch to read. Same sequence with repeated_start_cond=0 -> Sr aborts to IDLE, no ACK to 0x55.
- I2C_SLAVE_GENCALL_EN: address 0x00 plus byte 0x7E -> ACKed, rx_data=8'h7E. Without the macro -> NACK.
